rotr_arbiter: RTL and testbench
===============================

# rotr_arbiter

Shares a single 256-bit rotate-right unit (`Rotr`, registered, fixed pipeline latency) between two requesting ports of the BMI ALU. It:
- arbitrates the ports round-robin;
- drives the rotator's operand and shift inputs from an issue register;
- tracks tagged operations through the rotator pipeline;
- buffers results in a response FIFO so downstream backpressure never drops a result.

The rotator itself cannot stall. Credit-based issue throttling keeps the FIFO from overflowing.

## Interface
Parameters:
- `DATA_WIDTH`, 256: operand width. It is fixed at 256 by the rotator's 256:1 muxes, so `SHAMT_WIDTH` = 8.
- `LATENCY`, 1: rotator pipeline depth in cycles, from `rot_enable` cycle to `rot_result` valid.
- `TAG_WIDTH`, 4: requester-supplied tag, returned unchanged.
- `RSP_DEPTH`, 4: response FIFO depth. Minimum 1. Full throughput requires `RSP_DEPTH` ≥ `LATENCY`+2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low; one clock, no other clocks.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when ready and valid are both high.
- `req0_a` / `req1_a`  in  DATA_WIDTH  operand.
- `req0_shamt` / `req1_shamt`  in  8  rotate-right amount, taken modulo 256 by width.
- `req0_tag` / `req1_tag`  in  TAG_WIDTH  opaque tag.
- `rot_enable`  out  1  issue-register valid; drives rotator `enable`.
- `rot_a`  out  DATA_WIDTH  rotator `a_in`.
- `rot_shift`  out  DATA_WIDTH  rotator `shift_in`. Upper 248 bits are always 0; low 8 bits are the shift amount.
- `rot_result`  in  DATA_WIDTH  rotator `a_out`.
- `rsp_valid`  out  1  FIFO head valid.
- `rsp_ready`  in  1  consumer accepts the head.
- `rsp_data`  out  DATA_WIDTH  rotated result.
- `rsp_tag`  out  TAG_WIDTH  tag of the head entry.
- `rsp_src`  out  1  winning port of the head entry (0 or 1).

## Operation
**Credits**
- `used` = issue-register valid + in-flight pipeline valids + FIFO count.
- Issue is allowed when `used` < `RSP_DEPTH`.
- Credits return on a FIFO pop (`rsp_valid` and `rsp_ready`).
- A pop and an issue in the same cycle leave `used` unchanged.

**Arbitration**
- Round-robin with a `last` pointer; reset value is 1, so port 0 has first priority.
- When both ports are valid and issue is allowed, the port ≠ `last` wins.
- When only one port is valid, it wins.
- `last` updates only on a grant.
- `reqN_ready` = allowed and (port N is the winner). At most one ready is high per cycle.
- A ready may depend on the valids combinationally. No valid depends on a ready.

**Issue register**
- On a grant, loads {a, shamt, tag, src} and sets the valid bit.
- Otherwise clears the valid bit; data bits hold their previous value.

**Tracking**
- A `LATENCY`-deep shift register of {valid, tag, src} runs parallel to the rotator.
- When its output stage is valid, `rot_result` with that tag and src is written into the FIFO.
- The FIFO never overflows, because the credit rule guarantees space.

**FIFO**
- `RSP_DEPTH` entries, circular read/write pointers, registered head, no fall-through.
- A simultaneous push and pop is legal in every state, including when full.
- Pushing into an empty FIFO while popping nothing is also legal.

**Reset**
- `rst_n` low at any time, including with operations in flight, does all of the following:
  - clears all valids, `used`, and the FIFO pointers;
  - sets `last`=1;
  - drives `rot_enable`=0, `rot_a`=0, `rot_shift`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_tag`=0, `rsp_src`=0, `req0_ready`=0, `req1_ready`=0.
- In-flight results are discarded.
- The first grant is possible in the first cycle after `rst_n` deasserts.

## Timing
- Accept in cycle 0 → `rot_enable` in cycle 1 → rotator output valid in cycle 1+`LATENCY` → FIFO write at the end of that cycle → `rsp_valid` in cycle `LATENCY`+2. With defaults, that is cycle 3.
- Throughput is one operation per cycle when `RSP_DEPTH` ≥ `LATENCY`+2 and `rsp_ready` is held high.
- Results leave in issue order. There is no reordering across ports.
- When the FIFO is full and all credits are used, both readies are 0. Readiness returns in the cycle of a pop.

## Structure
- Package `rotr_pkg` holds the following:
  - `SHAMT_WIDTH`=8;
  - the typedef `rotr_entry_t` {data, tag, src};
  - the typedef `rotr_track_t` {valid, tag, src}.
- Sub-module `rotr_rsp_fifo`: a parameterised synchronous FIFO with count output.
- The rotator is instantiated outside this block, so the rotator can be replaced independently.

## Test plan
- **Single op:** reset, then req0 with a=256'h1, shamt=1, tag=3. Expect `rsp_data`=256'h1<<255, tag=3, src=0, `rsp_valid` rising in cycle 3.
- **Contention:** both ports valid for 4 cycles. Expect grants 0,1,0,1 and responses in the same order with their matching tags.
- **Backpressure:** hold `rsp_ready`=0 and stream on req1. Expect exactly 4 accepts, after which `req1_ready` stays 0. Raise `rsp_ready`: expect 4 ordered responses and issue resumes.
- **Wrap/modulo:** shamt=0 returns a unchanged. shamt=255 on a=256'h1 gives 256'h2.
- **Full with simultaneous push/pop:** FIFO full and `rsp_ready`=1 continuously. Expect one accept per cycle and no loss or duplication over 20 operations.
- **Reset mid-flight:** assert `rst_n`=0 with 3 ops in flight. Expect all outputs 0 immediately, no stale response after release, and a first new op that returns in cycle 3.

Source files
------------

// File: rtl/rotr_pkg.sv
// Shared widths and record types for the rotate-right arbiter slice.
package rotr_pkg;

    localparam int ROTR_DATA_WIDTH = 256;
    localparam int SHAMT_WIDTH     = 8;
    localparam int ROTR_TAG_WIDTH  = 4;

    typedef struct packed {
        logic [ROTR_DATA_WIDTH-1:0] data;
        logic [ROTR_TAG_WIDTH-1:0]  tag;
        logic                       src;
    } rotr_entry_t;

    typedef struct packed {
        logic                      valid;
        logic [ROTR_TAG_WIDTH-1:0] tag;
        logic                      src;
    } rotr_track_t;

endpackage

// File: rtl/rotr_rsp_fifo.sv
// Synchronous circular FIFO with registered storage, no fall-through, and an occupancy count.
module rotr_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= next_ptr(wptr);
            end
            if (do_pop) begin
                rptr <= next_ptr(rptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_valid = (cnt != '0);
    assign head_data  = mem[rptr];
    assign count      = cnt;

endmodule

// File: rtl/rotr_arbiter.sv
// Round-robin share of one external registered 256-bit rotator between two ports,
// with tag tracking through the rotator and a credit-protected response FIFO.
module rotr_arbiter
    import rotr_pkg::*;
#(
    parameter int DATA_WIDTH = ROTR_DATA_WIDTH,
    parameter int LATENCY    = 1,
    parameter int TAG_WIDTH  = ROTR_TAG_WIDTH,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [DATA_WIDTH-1:0]  req0_a,
    input  logic [SHAMT_WIDTH-1:0] req0_shamt,
    input  logic [TAG_WIDTH-1:0]   req0_tag,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [DATA_WIDTH-1:0]  req1_a,
    input  logic [SHAMT_WIDTH-1:0] req1_shamt,
    input  logic [TAG_WIDTH-1:0]   req1_tag,
    output logic                   rot_enable,
    output logic [DATA_WIDTH-1:0]  rot_a,
    output logic [DATA_WIDTH-1:0]  rot_shift,
    input  logic [DATA_WIDTH-1:0]  rot_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    output logic                   rsp_src
);

    localparam int USED_W = $clog2(RSP_DEPTH + LATENCY + 2) + 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

    logic                   last;
    logic                   winner;
    logic                   allowed;
    logic                   grant;
    logic                   pop;
    logic [USED_W-1:0]      used;
    logic                   issue_valid;
    logic [DATA_WIDTH-1:0]  issue_a;
    logic [SHAMT_WIDTH-1:0] issue_shamt;
    logic [TAG_WIDTH-1:0]   issue_tag;
    logic                   issue_src;
    rotr_track_t            track_q [LATENCY];
    rotr_entry_t            push_entry;
    rotr_entry_t            head_entry;
    logic [CNT_W-1:0]       fifo_count;

    assign pop = rsp_valid && rsp_ready;

    // Every op past the grant holds one credit until its result is popped.
    always_comb begin
        used = USED_W'(issue_valid) + USED_W'(fifo_count);
        for (int i = 0; i < LATENCY; i++) begin
            used = used + USED_W'(track_q[i].valid);
        end
    end

    assign allowed = rst_n && ((used < USED_W'(RSP_DEPTH)) || pop);

    always_comb begin
        winner = ~last;
        if (req0_valid && !req1_valid) begin
            winner = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            winner = 1'b1;
        end
    end

    assign grant      = allowed && (req0_valid || req1_valid);
    assign req0_ready = allowed && !winner;
    assign req1_ready = allowed && winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last        <= 1'b1;
            issue_valid <= 1'b0;
            issue_a     <= '0;
            issue_shamt <= '0;
            issue_tag   <= '0;
            issue_src   <= 1'b0;
        end else begin
            issue_valid <= grant;
            if (grant) begin
                last        <= winner;
                issue_a     <= winner ? req1_a     : req0_a;
                issue_shamt <= winner ? req1_shamt : req0_shamt;
                issue_tag   <= winner ? req1_tag   : req0_tag;
                issue_src   <= winner;
            end
        end
    end

    assign rot_enable = issue_valid;
    assign rot_a      = issue_a;
    assign rot_shift  = {{(DATA_WIDTH - SHAMT_WIDTH){1'b0}}, issue_shamt};

    // Tag pipeline mirrors the rotator's fixed latency so tags line up with rot_result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                track_q[i] <= '0;
            end
        end else begin
            track_q[0].valid <= issue_valid;
            track_q[0].tag   <= ROTR_TAG_WIDTH'(issue_tag);
            track_q[0].src   <= issue_src;
            for (int i = 1; i < LATENCY; i++) begin
                track_q[i] <= track_q[i-1];
            end
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.data = ROTR_DATA_WIDTH'(rot_result);
        push_entry.tag  = track_q[LATENCY-1].tag;
        push_entry.src  = track_q[LATENCY-1].src;
    end

    rotr_rsp_fifo #(
        .WIDTH ($bits(rotr_entry_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (track_q[LATENCY-1].valid),
        .push_data  (push_entry),
        .pop        (pop),
        .head_valid (rsp_valid),
        .head_data  (head_entry),
        .count      (fifo_count)
    );

    assign rsp_data = DATA_WIDTH'(head_entry.data);
    assign rsp_tag  = TAG_WIDTH'(head_entry.tag);
    assign rsp_src  = head_entry.src;

endmodule

// File: tb/tb_rotr_arbiter.sv
// Bench for rotr_arbiter: models the external rotator, scoreboards every response in issue order.
module tb_rotr_arbiter;

    localparam int DW = 256;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a = '0, req1_a = '0;
    logic [7:0]    req0_shamt = '0, req1_shamt = '0;
    logic [TW-1:0] req0_tag = '0, req1_tag = '0;
    logic          rot_enable;
    logic [DW-1:0] rot_a, rot_shift;
    logic [DW-1:0] rot_result = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_src;

    int total = 0;
    int bad = 0;
    logic [DW+TW:0] exp_q[$];

    rotr_arbiter #(
        .DATA_WIDTH (DW),
        .LATENCY    (1),
        .TAG_WIDTH  (TW),
        .RSP_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_shamt (req0_shamt),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_shamt (req1_shamt),
        .req1_tag   (req1_tag),
        .rot_enable (rot_enable),
        .rot_a      (rot_a),
        .rot_shift  (rot_shift),
        .rot_result (rot_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_src    (rsp_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference rotate: bit i of the result is bit (i+s) mod 256 of the operand.
    function automatic logic [DW-1:0] ref_rotr(input logic [DW-1:0] a, input logic [7:0] s);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) begin
            r[i] = a[(i + int'(s)) % DW];
        end
        return r;
    endfunction

    // Stand-in for the external registered rotator, one cycle of latency.
    always @(posedge clk) begin
        logic [2*DW-1:0] d;
        if (rot_enable) begin
            d = {rot_a, rot_a} >> rot_shift[7:0];
            rot_result <= d[DW-1:0];
        end
    end

    always @(negedge clk) begin
        logic [DW+TW:0] e;
        if (rst_n) begin
            if (req0_valid && req0_ready) exp_q.push_back({ref_rotr(req0_a, req0_shamt), req0_tag, 1'b0});
            if (req1_valid && req1_ready) exp_q.push_back({ref_rotr(req1_a, req1_shamt), req1_tag, 1'b1});
            if (rot_enable) check("rot_shift_hi", rot_shift >> 8, 264'h0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 264'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp", {rsp_data, rsp_tag, rsp_src}, e);
                end
            end
        end
    end

    task automatic load(input int p);
        if (p == 0) begin
            req0_a = {8{$urandom()}};
            req0_shamt = 8'($urandom_range(0, 255));
            req0_tag = 4'($urandom_range(0, 15));
        end else begin
            req1_a = {8{$urandom()}};
            req1_shamt = 8'($urandom_range(0, 255));
            req1_tag = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic check_reset_outs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_ctrl", {rot_enable, rsp_valid, rsp_src, req0_ready, req1_ready, rsp_tag}, 264'h0);
        check("rst_rot_a", rot_a, 264'h0);
        check("rst_rot_shift", rot_shift, 264'h0);
        check("rst_rsp_data", rsp_data, 264'h0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        check_reset_outs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input int p, input logic [DW-1:0] a, input logic [7:0] s, input logic [TW-1:0] t);
        logic hs;
        hs = 1'b0;
        if (p == 0) begin
            req0_a = a; req0_shamt = s; req0_tag = t; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_shamt = s; req1_tag = t; req1_valid = 1'b1;
        end
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = (p == 0) ? req0_ready : req1_ready;
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("send_accept", hs, 264'h1);
    endtask

    task automatic stream(input int p, input int ncyc, output int n_acc);
        logic hs;
        n_acc = 0;
        load(p);
        if (p == 0) req0_valid = 1'b1; else req1_valid = 1'b1;
        repeat (ncyc) begin
            @(negedge clk);
            hs = (p == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
            @(posedge clk);
            #1;
            if (hs) begin
                n_acc++;
                load(p);
            end
        end
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic lat_check(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) n = i;
        end
        check(name, n, 264'd3);
    endtask

    task automatic wait_rsp_data(input string name, input logic [DW-1:0] exp);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                check(name, rsp_data, exp);
            end
        end
        check({name, "_seen"}, seen, 264'h1);
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid && !rot_enable) break;
        end
        @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 264'h0);
    endtask

    initial begin
        int n;
        logic [DW-1:0] a;
        logic hs0;

        // Single op with reset checks and latency.
        do_reset();
        send(0, 256'h1, 8'd1, 4'd3);
        lat_check("single_latency");
        check("single_data", rsp_data, {1'b1, 255'h0});
        check("single_tag_src", {rsp_tag, rsp_src}, {4'd3, 1'b0});
        drain();

        // Contention: alternating grants starting at port 0.
        do_reset();
        load(0);
        load(1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            hs0 = req0_ready;
            check("cont_grant", {req1_ready, req0_ready}, (k % 2 == 1) ? 264'h2 : 264'h1);
            @(posedge clk);
            #1;
            if (hs0) load(0); else load(1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Backpressure: only credits-worth of accepts, then resume.
        rsp_ready = 1'b0;
        stream(1, 12, n);
        check("bp_accepts", n, 264'd4);
        req1_valid = 1'b1;
        @(negedge clk);
        check("bp_ready_low", {req1_ready, req0_ready}, 264'h0);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        stream(1, 8, n);
        check("bp_resume", n, 264'd8);
        drain();

        // Shift modulo edges.
        a = {8{$urandom()}};
        send(0, a, 8'd0, 4'd5);
        wait_rsp_data("shamt0", a);
        drain();
        send(1, 256'h1, 8'd255, 4'd6);
        wait_rsp_data("shamt255", 256'h2);
        drain();

        // Full FIFO with continuous pop: one accept every cycle.
        rsp_ready = 1'b0;
        stream(0, 6, n);
        check("full_fill", n, 264'd4);
        rsp_ready = 1'b1;
        stream(0, 20, n);
        check("full_stream", n, 264'd20);
        drain();

        // Reset with three ops in flight.
        rsp_ready = 1'b0;
        stream(0, 3, n);
        check("mid_accepts", n, 264'd3);
        rst_n = 1'b0;
        exp_q.delete();
        check_reset_outs();
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(1, {8{32'hA5A5_0F0F}}, 8'd17, 4'd9);
        lat_check("mid_latency");
        check("mid_tag_src", {rsp_tag, rsp_src}, {4'd9, 1'b1});
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
